ram_burst_master: RTL



---
 rtl/ram_burst_master_if.sv | 53 +++++
 rtl/ram_burst_master.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ram_burst_master_if.sv
// rtl/ram_burst_master_if.sv - command, write, read and RAM-port signals of the burst master
interface ram_burst_master_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 6
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    logic              busy;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_di;
    logic [DATA_W-1:0] ram_do;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rd_valid, rd_data, rd_last,
        input  rd_ready,
        output busy,
        output ram_en, ram_we, ram_addr, ram_di,
        input  ram_do
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rd_valid, rd_data, rd_last,
        output rd_ready,
        input  busy,
        input  ram_en, ram_we, ram_addr, ram_di,
        output ram_do
    );
endinterface

// File: rtl/ram_burst_master.sv
// rtl/ram_burst_master.sv - burst read/write initiator for a single-port registered-read RAM
module ram_burst_master #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 6
) (
    input  logic              CLK,
    input  logic              rst_n,
    ram_burst_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [LEN_W-1:0]  remaining, remaining_next;

    // one read can be outstanding inside the RAM; its tag says whether it is the burst's last beat
    logic              inflight;
    logic              inflight_last;

    logic [DATA_W-1:0] fifo_data [2];
    logic              fifo_last [2];
    logic              fifo_wr_ptr;
    logic              fifo_rd_ptr;
    logic [1:0]        fifo_count;

    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        occupancy;

    logic              cmd_ready_c;
    logic              wr_ready_c;
    logic              ram_en_c;
    logic              ram_we_c;

    assign pop  = (fifo_count != 2'd0) && bus.rd_ready;
    assign push = inflight;

    // slots already claimed after this cycle's pop; a new read may only go out if one stays free
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == READ) && (occupancy < 3'd2);

    // next-state and RAM command decode
    always_comb begin
        state_next     = state;
        addr_next      = addr;
        remaining_next = remaining;
        cmd_ready_c    = 1'b0;
        wr_ready_c     = 1'b0;
        ram_en_c       = 1'b0;
        ram_we_c       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    addr_next      = bus.cmd_addr;
                    remaining_next = bus.cmd_len;
                    state_next     = bus.cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready_c = 1'b1;
                if (bus.wr_valid) begin
                    ram_en_c       = 1'b1;
                    ram_we_c       = 1'b1;
                    addr_next      = addr + ADDR_W'(1);
                    remaining_next = remaining - LEN_W'(1);
                    if (remaining == '0) begin
                        state_next = IDLE;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    ram_en_c       = 1'b1;
                    addr_next      = addr + ADDR_W'(1);
                    remaining_next = remaining - LEN_W'(1);
                    if (remaining == '0) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight && (fifo_count == 2'd0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // state, burst address and beat counter registers
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
        end else begin
            state     <= state_next;
            addr      <= addr_next;
            remaining <= remaining_next;
        end
    end

    // track the read sitting in the RAM pipeline; it lands in the FIFO on the following edge
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_last <= (remaining == '0);
            end
        end
    end

    // two-entry read-return FIFO absorbing RAM latency under response backpressure
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[fifo_wr_ptr] <= bus.ram_do;
                fifo_last[fifo_wr_ptr] <= inflight_last;
                fifo_wr_ptr            <= ~fifo_wr_ptr;
            end
            if (pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // the issue throttle guarantees a full FIFO never has a read in flight
    a_no_overflow: assert property (@(posedge CLK) disable iff (!rst_n)
        push |-> (fifo_count != 2'd2));

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.wr_ready  = wr_ready_c;
    assign bus.ram_en    = ram_en_c;
    assign bus.ram_we    = ram_we_c;
    assign bus.ram_addr  = addr;
    assign bus.ram_di    = bus.wr_data;
    assign bus.rd_valid  = (fifo_count != 2'd0);
    assign bus.rd_data   = fifo_data[fifo_rd_ptr];
    assign bus.rd_last   = fifo_last[fifo_rd_ptr];
    assign bus.busy      = (state != IDLE);
endmodule
